// File: rtl/vector_deser_pkg.sv
// Shared constants and helpers for the vector deserialiser FIFO.
//   DEF_WIDTH / DEF_DEPTH : default vector width and FIFO depth
//   count_width()         : width of an occupancy counter, clog2(depth+1)
//   LSB_FIRST / MSB_FIRST : encoding of the lsb_first input
package vector_deser_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    localparam logic LSB_FIRST = 1'b1;
    localparam logic MSB_FIRST = 1'b0;

    // Occupancy counter must be able to represent DEPTH itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vector_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_push / i_data    : write request and data
//   i_pop              : read request (ignored when empty)
//   i_flush            : synchronous clear, overrides push and pop
//   o_data             : head entry, 0 when empty
//   o_full / o_empty   : status flags
//   o_count            : entries held, 0..DEPTH
// A push while full is accepted only if a pop happens on the same edge.
module vector_fifo
    import vector_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CW = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    // Full is not a blocker when the same edge frees the head slot.
    assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/vector_deser_fifo.sv
// Serial-to-parallel assembler feeding a FWFT vector FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   input_bit  : serial data bit, sampled when bit_valid=1
//   bit_valid  : qualifies input_bit on this edge
//   lsb_first  : bit order for the word starting on this edge (1 = LSB first)
//   flush      : synchronous clear of FIFO, partial word and overflow
//   req        : consumer pop request
//   vector     : head FIFO entry, 0 when empty
//   valid      : FIFO non-empty
//   count      : entries held
//   overflow   : sticky, a completed word was dropped on a full FIFO
module vector_deser_fifo
    import vector_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CW = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             input_bit,
    input  logic             bit_valid,
    input  logic             lsb_first,
    input  logic             flush,
    input  logic             req,
    output logic [WIDTH-1:0] vector,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam int unsigned BW = $clog2(WIDTH);

    logic [BW-1:0]    r_bcnt;
    logic [WIDTH-1:0] r_asm;
    logic             r_order;
    logic             r_overflow;

    logic             w_first;
    logic             w_last;
    logic             w_order;
    logic [BW-1:0]    w_pos;
    logic [WIDTH-1:0] w_word;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    assign w_first = (r_bcnt == '0);
    assign w_last  = (r_bcnt == BW'(WIDTH - 1));
    // The first bit of a word uses the live order input; later bits use the latch.
    assign w_order = w_first ? lsb_first : r_order;
    assign w_pos   = (w_order == LSB_FIRST) ? r_bcnt : (BW'(WIDTH - 1) - r_bcnt);

    // Partial word with the current bit merged in, so completion pushes all WIDTH bits.
    always_comb begin
        w_word        = r_asm;
        w_word[w_pos] = input_bit;
    end

    assign w_push = bit_valid && w_last && !flush;
    assign w_pop  = req && !w_empty;

    // Bit counter, assembly register and order latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_asm   <= '0;
            r_order <= MSB_FIRST;
        end else if (flush) begin
            r_bcnt  <= '0;
            r_asm   <= '0;
        end else if (bit_valid) begin
            if (w_first) begin
                r_order <= lsb_first;
            end
            if (w_last) begin
                r_bcnt <= '0;
                r_asm  <= '0;
            end else begin
                r_bcnt <= r_bcnt + BW'(1);
                r_asm  <= w_word;
            end
        end
    end

    // Sticky overflow: a completed word found the FIFO full with no pop to make room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    vector_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (req),
        .i_flush (flush),
        .o_data  (vector),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign valid    = !w_empty;
    assign overflow = r_overflow;

endmodule

// File: doc/vector_deser_fifo.md
Name: vector_deser_fifo

Overview:
- Parametrised successor to the single-vector serial-to-parallel buffer.
- Assembles a serial bit stream into WIDTH-bit vectors, with selectable MSB-first or LSB-first bit order.
- Completed vectors queue in a DEPTH-entry first-word-fall-through FIFO, drained by a req/valid handshake.
- Sits between the serial input pins and the downstream vector consumer; adds occupancy, sticky overflow and synchronous flush.

Parameters:
WIDTH, 8, bits per assembled vector; must be >= 2.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
input_bit  input  1  serial data bit.
bit_valid  input  1  input_bit is sampled on this edge when high.
lsb_first  input  1  bit order: 1 = first bit lands in vector[0]; 0 = first bit lands in vector[WIDTH-1].
flush  input  1  synchronous clear of the FIFO, partial word and overflow.
req  input  1  consumer pop request.
vector  output  WIDTH  head FIFO entry; 0 when valid=0.
valid  output  1  FIFO non-empty.
count  output  CW  entries held, where CW = $clog2(DEPTH+1).
overflow  output  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, asynchronous): bit counter 0, assembly register 0, pointers 0, count 0, valid 0, vector 0, overflow 0, latched order 0.
- Assembly:
  - bit counter bcnt runs 0..WIDTH-1 and advances only on cycles with bit_valid=1; gaps of any length are allowed.
  - lsb_first is latched on the edge where bit_valid=1 and bcnt=0, then held for the whole word. Changes mid-word are ignored.
  - Bit k of a word (k=0 is first) is written to position k in LSB-first order, or WIDTH-1-k in MSB-first order.
- Word completion: on an edge with bit_valid=1 and bcnt=WIDTH-1:
  - The full word, including this final bit, is pushed.
  - bcnt returns to 0 and the assembly register clears.
  - Latency: valid/vector/count reflect the push in the cycle after that edge.
- Pop: occurs on an edge with req=1 and valid=1. req with valid=0 is ignored, with no error.
  - vector is combinational from the registered head entry.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because the pop frees the slot; overflow is not set.
  - When count=1, valid stays 1 and vector shows the new word next cycle.
- Full, with push and no pop: the word is discarded, FIFO contents are unchanged, and overflow sets to 1.
- overflow clears only on reset or flush.
- Empty: valid=0 and vector=0.
- Pointers wrap modulo DEPTH; count saturates naturally at DEPTH and never exceeds it.
- flush has highest priority on its edge:
  - Clears pointers, count, bcnt, assembly register and overflow.
  - input_bit and req presented on that edge are discarded.
  - The next bit_valid starts a fresh word.
- Reset mid-word behaves the same as flush, but asynchronously.

Decomposition:
- Package vector_deser_pkg holds:
  - default WIDTH and DEPTH constants;
  - a count-width function, clog2(DEPTH+1);
  - the bit-order encoding constants LSB_FIRST=1 and MSB_FIRST=0.
- Sub-module vector_fifo: generic FWFT synchronous FIFO (WIDTH, DEPTH) with push, pop, flush, full, empty and count.
- The top level contains the assembler, order latch and overflow logic only.

Test Plan:
(WIDTH=8, DEPTH=4)
1. Reset: hold rst_n=0 with random input_bit/bit_valid -> valid=0, vector=0, count=0, overflow=0 throughout; release -> unchanged until 8 valid bits arrive.
2. Bit order: bits 1,1,0,0,0,0,0,0 with lsb_first=0 -> vector=8'hC0, valid=1 exactly one cycle after the 8th bit. Repeat with lsb_first=1 -> 8'h03. Toggle lsb_first at bit 3 -> order unaffected.
3. Gapped input: same bits with bit_valid low for 3 cycles between each bit -> identical result; req pulse -> valid=0, count=0 the next cycle.
4. Overflow: push 5 words 8'h11, 22, 33, 44, 55 with req=0 -> count=4, overflow=1. Pops return 11, 22, 33, 44; 55 is lost; overflow stays 1 until flush.
5. Full with simultaneous push and pop: fill with 4 words, hold req=1 on the completion edge of word 5 -> count stays 4, overflow=0, pop order intact.
6. Flush mid-word: send 3 bits, assert flush, then send 8'hA5 MSB-first -> vector=8'hA5, count=1. Repeat with async rst_n low mid-word -> same outcome.
